// File: rtl/pick_anim_sched.sv
// Per-frame orbit sequencer: walks the ball slots through the shared rotation
// lookup and writes one coordinate pair per slot into the pixel table.
// Optional macro PICK_ACK_TIMEOUT_EN adds a bounded wait on rot_ack.
//
// Ports:
//   CLK, Reset                    clock, asynchronous active-high reset
//   frame_start                   one-cycle pulse at vertical blanking
//   centerX, centerY, radius      orbit geometry, shadowed per frame
//   speed                         angle advance per frame (0..15)
//   rot_req/radius/phase/angle    request to the rotation lookup
//   rot_ack, rot_x, rot_y         lookup response
//   coord_we/slot_idx/coord_x/y   coordinate table write port
//   busy, done, overrun           status; overrun is sticky
//   err_timeout                   sticky ack timeout (0 without macro)
module pick_anim_sched #(
   parameter int NUM_SLOTS   = 10,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       frame_start,
   input  logic [9:0] centerX,
   input  logic [9:0] centerY,
   input  logic [9:0] radius,
   input  logic [3:0] speed,
   output logic       rot_req,
   output logic [9:0] rot_radius,
   output logic [1:0] rot_phase,
   output logic [9:0] rot_angle,
   input  logic       rot_ack,
   input  logic [9:0] rot_x,
   input  logic [9:0] rot_y,
   output logic       coord_we,
   output logic [3:0] slot_idx,
   output logic [9:0] coord_x,
   output logic [9:0] coord_y,
   output logic       busy,
   output logic       done,
   output logic       overrun,
   output logic       err_timeout
);

   if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || ACK_TIMEOUT < 1) begin : g_bad_cfg
      $error("pick_anim_sched: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [3:0] LAST = 4'(NUM_SLOTS - 1);

   state_t     state_q, state_d;
   logic [3:0] slot_q, slot_d;
   logic [9:0] angle_q, angle_d;
   logic [9:0] cx_q, cx_d;
   logic [9:0] cy_q, cy_d;
   logic [9:0] rad_q, rad_d;
   logic [9:0] ang_sh_q, ang_sh_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       req_q, we_q, done_q;
   logic       ovr_q, ovr_d;
   logic [10:0] ang_sum;
   logic [9:0] off_w;

   function automatic logic [6:0] slot_off(input logic [3:0] s);
      case (s)
         4'd0:    return 7'd30;
         4'd1:    return 7'd40;
         4'd2:    return 7'd50;
         4'd3:    return 7'd60;
         4'd4:    return 7'd70;
         4'd5:    return 7'd80;
         4'd6:    return 7'd90;
         4'd7:    return 7'd80;
         4'd8:    return 7'd80;
         default: return 7'd100;
      endcase
   endfunction

   function automatic logic [1:0] slot_phase(input logic [3:0] s);
      case (s)
         4'd7:    return 2'd1;
         4'd8:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Saturating subtract: small orbits collapse to the centre instead of wrapping.
   assign off_w      = {3'd0, slot_off(slot_q)};
   assign rot_radius = (rad_q < off_w) ? 10'd0 : rad_q - off_w;
   assign rot_phase  = slot_phase(slot_q);
   assign rot_angle  = ang_sh_q;
   assign ang_sum    = {1'b0, angle_q} + {7'd0, speed};

`ifdef PICK_ACK_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      angle_d  = angle_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      rad_d    = rad_q;
      ang_sh_d = ang_sh_q;
      x_d      = x_q;
      y_d      = y_q;
      // Any pulse outside IDLE (DONE included) is a missed frame.
      ovr_d    = ovr_q | (frame_start && state_q != S_IDLE);
`ifdef PICK_ACK_TIMEOUT_EN
      tmo_d    = '0;
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               cx_d     = centerX;
               cy_d     = centerY;
               rad_d    = radius;
               ang_sh_d = angle_q;
               slot_d   = 4'd0;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (rot_ack) begin
               // Lookup returns an offset from the orbit centre.
               x_d     = cx_q + rot_x;
               y_d     = cy_q + rot_y;
               state_d = S_WRITE;
            end
`ifdef PICK_ACK_TIMEOUT_EN
            else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
               x_d     = 10'h3FF;
               y_d     = 10'h3FF;
               err_d   = 1'b1;
               state_d = S_WRITE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         S_WRITE: begin
            if (slot_q == LAST) begin
               state_d = S_DONE;
            end else begin
               slot_d  = slot_q + 4'd1;
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            angle_d = (ang_sum >= 11'd360) ? 10'(ang_sum - 11'd360)
                                           : ang_sum[9:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         slot_q   <= '0;
         angle_q  <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         rad_q    <= '0;
         ang_sh_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef PICK_ACK_TIMEOUT_EN
         tmo_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         angle_q  <= angle_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         rad_q    <= rad_d;
         ang_sh_q <= ang_sh_d;
         x_q      <= x_d;
         y_q      <= y_d;
         // Strobes come straight from flops, decoded from the next state.
         req_q    <= (state_d == S_REQ);
         we_q     <= (state_d == S_WRITE);
         done_q   <= (state_d == S_DONE);
         ovr_q    <= ovr_d;
`ifdef PICK_ACK_TIMEOUT_EN
         tmo_q    <= tmo_d;
         err_q    <= err_d;
`endif
      end
   end

   assign rot_req  = req_q;
   assign coord_we = we_q;
   assign done     = done_q;
   assign slot_idx = slot_q;
   assign coord_x  = x_q;
   assign coord_y  = y_q;
   assign busy     = (state_q != S_IDLE);
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_pick_anim_sched.sv
// Scoreboard bench for pick_anim_sched: a frame-level model queues the
// expected requests and writes; a monitor checks them as the DUT emits them.
module tb_pick_anim_sched;
   localparam int NS = 10;
   localparam int TO = 16;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       frame_start;
   logic [9:0] centerX, centerY, radius;
   logic [3:0] speed;
   logic       rot_req;
   logic [9:0] rot_radius;
   logic [1:0] rot_phase;
   logic [9:0] rot_angle;
   logic       rot_ack;
   logic [9:0] rot_x, rot_y;
   logic       coord_we;
   logic [3:0] slot_idx;
   logic [9:0] coord_x, coord_y;
   logic       busy, done, overrun, err_timeout;

   pick_anim_sched #(.NUM_SLOTS(NS), .ACK_TIMEOUT(TO)) dut (
      .CLK(CLK), .Reset(Reset), .frame_start(frame_start),
      .centerX(centerX), .centerY(centerY), .radius(radius), .speed(speed),
      .rot_req(rot_req), .rot_radius(rot_radius), .rot_phase(rot_phase),
      .rot_angle(rot_angle), .rot_ack(rot_ack), .rot_x(rot_x), .rot_y(rot_y),
      .coord_we(coord_we), .slot_idx(slot_idx), .coord_x(coord_x),
      .coord_y(coord_y), .busy(busy), .done(done), .overrun(overrun),
      .err_timeout(err_timeout)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int slot; int rad; int ph; int ang; int x; int y;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int ack_mode = 0;
   int t0 = 0;
   bit chk_lat = 0;
   bit jitter  = 0;
   int frames_open = 0;
   int angle_m = 0;
   int OFF[10] = '{30, 40, 50, 60, 70, 80, 90, 80, 80, 100};
   int PH[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 0};

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int lut_x(int r, int p, int a);
      return (r + 3 * a + 7 * p) % 1024;
   endfunction

   function automatic int lut_y(int r, int p, int a);
      return (((5 * r) ^ a) + 11 * p) % 1024;
   endfunction

   // Lookup stand-in: answers with a fixed function of the request.
   initial begin
      rot_ack = 1'b0; rot_x = '0; rot_y = '0;
      forever begin
         @(negedge CLK);
         rot_x = 10'(lut_x(int'(rot_radius), int'(rot_phase), int'(rot_angle)));
         rot_y = 10'(lut_y(int'(rot_radius), int'(rot_phase), int'(rot_angle)));
         case (ack_mode)
            0:       rot_ack = 1'b1;
            1:       rot_ack = ($urandom_range(0, 2) != 0);
            default: rot_ack = 1'b0;
         endcase
      end
   end

   // Frame model: slot table, saturation, centre offset, angle wrap.
   task automatic push_frame(int cx, int cy, int r, int spd, bit tmo);
      exp_t e;
      for (int s = 0; s < NS; s++) begin
         int off;
         off   = (s < 10) ? OFF[s] : 100;
         e.slot = s;
         e.rad  = (r > off) ? r - off : 0;
         e.ph   = (s < 10) ? PH[s] : 0;
         e.ang  = angle_m;
         if (tmo) begin
            e.x = 1023; e.y = 1023;
         end else begin
            e.x = (cx + lut_x(e.rad, e.ph, e.ang)) % 1024;
            e.y = (cy + lut_y(e.rad, e.ph, e.ang)) % 1024;
         end
         q.push_back(e);
      end
      angle_m = (angle_m + spd) % 360;
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         if (!Reset) begin
            if (rot_req) begin
               if (q.size() == 0) check("req_unexpected", 1, 0);
               else begin
                  check("rot_radius", rot_radius, q[0].rad);
                  check("rot_phase", rot_phase, q[0].ph);
                  check("rot_angle", rot_angle, q[0].ang);
                  check("req_slot", slot_idx, q[0].slot);
               end
            end
            if (coord_we) begin
               if (q.size() == 0) check("we_unexpected", 1, 0);
               else begin
                  exp_t e;
                  e = q.pop_front();
                  check("slot_idx", slot_idx, e.slot);
                  check("coord_x", coord_x, e.x);
                  check("coord_y", coord_y, e.y);
                  if (chk_lat && e.slot == 0) check("first_we_cycle", cyc - t0, 2);
               end
            end
            if (done) begin
               check("done_frame_open", frames_open, 1);
               check("done_pending_writes", q.size(), 0);
               if (chk_lat) check("done_cycle", cyc - t0, 2 * NS + 1);
               if (frames_open > 0) frames_open--;
            end
         end
      end
   end

   task automatic start_frame(int cx, int cy, int r, int spd, bit lat, bit tmo);
      @(negedge CLK);
      centerX = 10'(cx); centerY = 10'(cy); radius = 10'(r);
      speed = 4'(spd);
      frame_start = 1'b1;
      t0 = cyc;
      chk_lat = lat;
      push_frame(cx, cy, r, spd, tmo);
      frames_open++;
      @(negedge CLK);
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2 Reset = 1'b1;
      #1 q.delete();
      frames_open = 0;
      angle_m = 0;
      @(negedge CLK);
      Reset = 1'b0;
   endtask

   task automatic wait_idle(int budget);
      int n = 0;
      while (frames_open != 0 && n < budget) begin
         @(negedge CLK);
         if (jitter) begin
            centerX = 10'($urandom); centerY = 10'($urandom);
            radius = 10'($urandom);
         end
         n++;
      end
      if (frames_open != 0) begin
         check("frame_completes", 0, 1);
         do_reset();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1; frame_start = 1'b0;
      centerX = '0; centerY = '0; radius = '0; speed = '0;
      repeat (3) @(negedge CLK);
      check("rst_ctrl", int'({rot_req, coord_we, busy, done, overrun, err_timeout}), 0);
      check("rst_data", int'(|{slot_idx, coord_x, coord_y, rot_radius, rot_angle, rot_phase}), 0);
      Reset = 1'b0;
      repeat (5) @(negedge CLK);
      check("idle_busy", busy, 0);

      start_frame(320, 240, 150, 0, 1, 0);
      wait_idle(100);
      start_frame(100, 100, 60, 3, 1, 0);
      wait_idle(100);
      check("overrun_clear", overrun, 0);
      check("err_clear", err_timeout, 0);

      // Extra pulse at cycle 5 of a frame.
      start_frame(500, 400, 200, 1, 1, 0);
      repeat (4) @(negedge CLK);
      check("busy_mid", busy, 1);
      frame_start = 1'b1;
      @(negedge CLK);
      frame_start = 1'b0;
      wait_idle(100);
      check("overrun_set", overrun, 1);

      // Pulse landing on the DONE cycle.
      do_reset();
      check("overrun_after_rst", overrun, 0);
      start_frame(10, 20, 300, 2, 1, 0);
      repeat (20) @(negedge CLK);
      check("done_at_21", done, 1);
      frame_start = 1'b1;
      @(negedge CLK);
      frame_start = 1'b0;
      repeat (5) @(negedge CLK);
      check("busy_after_done_pulse", busy, 0);
      check("overrun_done_pulse", overrun, 1);

      // Reset during slot 4 request.
      do_reset();
      start_frame(111, 222, 400, 5, 1, 0);
      repeat (8) @(negedge CLK);
      check("slot4_req", rot_req, 1);
      check("slot4_idx", slot_idx, 4);
      #2 Reset = 1'b1;
      #1;
      check("midrst_ctrl", int'({rot_req, coord_we, busy, done, overrun, err_timeout}), 0);
      check("midrst_data", int'(|{slot_idx, coord_x, coord_y, rot_radius, rot_angle}), 0);
      q.delete(); frames_open = 0; angle_m = 0;
      @(negedge CLK);
      Reset = 1'b0;
      repeat (20) @(negedge CLK);
      check("post_rst_busy", busy, 0);

      // Angle wrap: 23*15 + 12 = 357, then +7 -> 4.
      jitter = 1'b1;
      for (int i = 0; i < 23; i++) begin
         start_frame(300, 200, 250, 15, 1, 0);
         wait_idle(100);
      end
      start_frame(300, 200, 250, 12, 1, 0);
      wait_idle(100);
      start_frame(300, 200, 250, 7, 1, 0);
      wait_idle(100);
      start_frame(300, 200, 250, 0, 1, 0);
      check("angle_wrapped", rot_angle, 4);
      wait_idle(100);

      // Random ack timing, geometry and speed.
      ack_mode = 1;
      for (int i = 0; i < 40; i++) begin
         start_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                     int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)), 0, 0);
         wait_idle(2000);
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      jitter = 1'b0;

      // Lookup never answers.
      do_reset();
      ack_mode = 2;
`ifdef PICK_ACK_TIMEOUT_EN
      start_frame(50, 60, 150, 1, 0, 1);
      repeat (15) @(negedge CLK);
      check("tmo_still_req", rot_req, 1);
      @(negedge CLK);
      check("tmo_write_c17", coord_we, 1);
      check("tmo_err", err_timeout, 1);
      wait_idle(NS * (TO + 1) + 20);
      check("tmo_err_sticky", err_timeout, 1);
`else
      start_frame(50, 60, 150, 1, 0, 0);
      repeat (50) @(negedge CLK);
      check("stall_req", rot_req, 1);
      check("stall_busy", busy, 1);
      check("stall_err", err_timeout, 0);
      check("stall_no_write", q.size(), NS);
`endif
      do_reset();
      ack_mode = 0;
      check("final_err", err_timeout, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
